mor1kx_dpram_fifo_ctrl: RTL and testbench

Single-clock first-word-fall-through FIFO controller that drives an external true dual-port RAM. It converts a valid/ready write stream into port-A RAM writes and port-B RAM reads. It hides the RAM's one-cycle registered read latency behind a 2-entry output buffer, so it sustains one word per cycle. It sits directly upstream and downstream of the dual-port RAM: it feeds addresses and write data into it and consumes its port-B read data.

---
 rtl/mor1kx_dpram_fifo_ctrl_if.sv | 33 +++
 rtl/mor1kx_dpram_fifo_ctrl.sv | 122 ++++++++++++
 tb/tb_mor1kx_dpram_fifo_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mor1kx_dpram_fifo_ctrl_if.sv
// rtl/mor1kx_dpram_fifo_ctrl_if.sv - stream, occupancy and dual-port RAM signals of the FIFO controller
interface mor1kx_dpram_fifo_ctrl_if #(
  parameter int DEPTH_WIDTH = 4,
  parameter int DATA_WIDTH  = 32
);
  logic                   flush;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [DATA_WIDTH-1:0]  wr_data;
  logic                   rd_valid;
  logic                   rd_ready;
  logic [DATA_WIDTH-1:0]  rd_data;
  logic [DEPTH_WIDTH+1:0] count;
  logic [DEPTH_WIDTH-1:0] ram_addr_a;
  logic                   ram_we_a;
  logic [DATA_WIDTH-1:0]  ram_din_a;
  logic [DEPTH_WIDTH-1:0] ram_addr_b;
  logic [DATA_WIDTH-1:0]  ram_dout_b;

  // Controller side
  modport slave (
    input  flush, wr_valid, wr_data, rd_ready, ram_dout_b,
    output wr_ready, rd_valid, rd_data, count,
           ram_addr_a, ram_we_a, ram_din_a, ram_addr_b
  );

  // Producer/consumer/RAM side
  modport master (
    output flush, wr_valid, wr_data, rd_ready, ram_dout_b,
    input  wr_ready, rd_valid, rd_data, count,
           ram_addr_a, ram_we_a, ram_din_a, ram_addr_b
  );
endinterface

// File: rtl/mor1kx_dpram_fifo_ctrl.sv
// rtl/mor1kx_dpram_fifo_ctrl.sv - FWFT FIFO controller over a dual-port RAM; MOR1KX_FIFO_BYPASS_EN enables empty-FIFO head bypass
module mor1kx_dpram_fifo_ctrl #(
  parameter int DEPTH_WIDTH = 4,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  mor1kx_dpram_fifo_ctrl_if.slave       bus
);

  localparam int unsigned RAM_WORDS = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] RAM_FULL = RAM_WORDS[DEPTH_WIDTH:0];

  logic [DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_WIDTH:0]   ram_count_q, ram_count_d;
  logic                   fetch_pending_q, fetch_pending_d;
  logic [DATA_WIDTH-1:0]  head_q, head_d;
  logic [DATA_WIDTH-1:0]  skid_q, skid_d;
  logic [1:0]             occ_q, occ_d;
  logic [DEPTH_WIDTH+1:0] count_q, count_d;

  logic                   wr_ready;
  logic                   pop;
  logic                   push;
  logic                   bypass;
  logic                   ram_push;
  logic                   fetch;
  logic [2:0]             demand;
  logic [1:0]             occ_after;
  logic                   in_valid;
  logic [DATA_WIDTH-1:0]  in_data;

  // Handshake decode: accept, pop, optional bypass, and fetch issue
  always_comb begin
    wr_ready = (ram_count_q != RAM_FULL);
    pop      = (occ_q != 2'd0) && bus.rd_ready;
    push     = bus.wr_valid && wr_ready;
`ifdef MOR1KX_FIFO_BYPASS_EN
    bypass   = push && (ram_count_q == '0) && !fetch_pending_q &&
               ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop));
`else
    bypass   = 1'b0;
`endif
    ram_push = push && !bypass;
    // Slots that will be claimed once this cycle's pop and any returning fetch settle
    demand   = 3'(occ_q) + 3'(fetch_pending_q) - 3'(pop);
    fetch    = (ram_count_q != '0) && (demand < 3'd2);
  end

  // Next-state for pointers, RAM occupancy, output buffer and registered count
  always_comb begin
    wr_ptr_d        = ram_push ? wr_ptr_q + DEPTH_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d        = fetch ? rd_ptr_q + DEPTH_WIDTH'(1) : rd_ptr_q;
    ram_count_d     = ram_count_q + (DEPTH_WIDTH+1)'(ram_push) - (DEPTH_WIDTH+1)'(fetch);
    fetch_pending_d = fetch;

    head_d    = head_q;
    skid_d    = skid_q;
    occ_after = occ_q - 2'(pop);
    if (pop && (occ_q == 2'd2)) begin
      head_d = skid_q;
    end

    // Returning RAM data and bypassed writes are mutually exclusive
    in_valid = fetch_pending_q || bypass;
    in_data  = fetch_pending_q ? bus.ram_dout_b : bus.wr_data;
    occ_d    = occ_after;
    if (in_valid) begin
      if (occ_after == 2'd0) begin
        head_d = in_data;
      end else begin
        skid_d = in_data;
      end
      occ_d = occ_after + 2'd1;
    end

    if (bus.flush) begin
      wr_ptr_d        = '0;
      rd_ptr_d        = '0;
      ram_count_d     = '0;
      fetch_pending_d = 1'b0;
      occ_d           = 2'd0;
    end

    count_d = (DEPTH_WIDTH+2)'(ram_count_d) + (DEPTH_WIDTH+2)'(fetch_pending_d) +
              (DEPTH_WIDTH+2)'(occ_d);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      ram_count_q     <= '0;
      fetch_pending_q <= 1'b0;
      head_q          <= '0;
      skid_q          <= '0;
      occ_q           <= 2'd0;
      count_q         <= '0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      ram_count_q     <= ram_count_d;
      fetch_pending_q <= fetch_pending_d;
      head_q          <= head_d;
      skid_q          <= skid_d;
      occ_q           <= occ_d;
      count_q         <= count_d;
    end
  end

  assign bus.wr_ready   = wr_ready;
  assign bus.rd_valid   = (occ_q != 2'd0);
  assign bus.rd_data    = head_q;
  assign bus.count      = count_q;
  assign bus.ram_addr_a = wr_ptr_q;
  assign bus.ram_we_a   = ram_push;
  assign bus.ram_din_a  = bus.wr_data;
  assign bus.ram_addr_b = rd_ptr_q;

endmodule

// File: tb/tb_mor1kx_dpram_fifo_ctrl.sv
// tb/tb_mor1kx_dpram_fifo_ctrl.sv - scoreboard bench for the dual-port RAM FIFO controller
module tb_mor1kx_dpram_fifo_ctrl;

  localparam int DW = 4;
  localparam int XW = 32;

  logic clk;
  logic rst_n;

  mor1kx_dpram_fifo_ctrl_if #(.DEPTH_WIDTH(DW), .DATA_WIDTH(XW)) bus ();

  mor1kx_dpram_fifo_ctrl #(.DEPTH_WIDTH(DW), .DATA_WIDTH(XW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External dual-port RAM with registered port-B read
  logic [XW-1:0] mem [1<<DW];
  always @(posedge clk) begin
    if (bus.ram_we_a) mem[bus.ram_addr_a] <= bus.ram_din_a;
    bus.ram_dout_b <= mem[bus.ram_addr_b];
  end

  logic [XW-1:0] sb [$];
  int n_checks = 0;
  int n_bad    = 0;
  bit last_acc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: sample handshakes at negedge, update the scoreboard, settle after posedge
  task automatic tick();
    logic acc;
    logic pp;
    logic [XW-1:0] exp;
    @(negedge clk);
    acc = bus.wr_valid && bus.wr_ready;
    pp  = bus.rd_valid && bus.rd_ready;
    last_acc = 1'b0;
    if (!rst_n || bus.flush) begin
      sb.delete();
    end else begin
      if (pp) begin
        check_eq("pop_has_expected", 64'(sb.size() != 0), 64'(pp));
        if (sb.size() != 0) begin
          exp = sb.pop_front();
          check_eq("rd_data", 64'(bus.rd_data), 64'(exp));
        end
      end
      if (acc) begin
        sb.push_back(bus.wr_data);
        last_acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_eq("count", 64'(bus.count), 64'(sb.size()));
  endtask

  task automatic push_word(input logic [XW-1:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (last_acc) break;
    end
    check_eq("push_accepted", 64'(last_acc), 64'(1));
    bus.wr_valid = 1'b0;
  endtask

  task automatic drain();
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 300 && sb.size() != 0; i++) tick();
    check_eq("drain_empty", 64'(sb.size()), 64'(0));
    tick();
    check_eq("drain_rd_valid", 64'(bus.rd_valid), 64'(0));
    bus.rd_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_rd_valid"},   64'(bus.rd_valid),   64'(0));
    check_eq({pfx, "_count"},      64'(bus.count),      64'(0));
    check_eq({pfx, "_rd_data"},    64'(bus.rd_data),    64'(0));
    check_eq({pfx, "_wr_ready"},   64'(bus.wr_ready),   64'(1));
    check_eq({pfx, "_ram_we_a"},   64'(bus.ram_we_a),   64'(0));
    check_eq({pfx, "_ram_addr_a"}, 64'(bus.ram_addr_a), 64'(0));
    check_eq({pfx, "_ram_addr_b"}, 64'(bus.ram_addr_b), 64'(0));
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    rst_n        = 1'b0;
    bus.flush    = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.rd_ready = 1'b0;

    // Reset
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check_reset_outputs("reset");

    // Single word latency: push edge N, fetch edge N+1, head valid after N+2
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'hA5A5_0001;
    #1;
    check_eq("single_we_a", 64'(bus.ram_we_a), 64'(1));
    check_eq("single_addr_a", 64'(bus.ram_addr_a), 64'(0));
    tick();
    bus.wr_valid = 1'b0;
    check_eq("single_valid_n0", 64'(bus.rd_valid), 64'(0));
    tick();
    check_eq("single_valid_n1", 64'(bus.rd_valid), 64'(0));
    tick();
    check_eq("single_valid_n2", 64'(bus.rd_valid), 64'(1));
    check_eq("single_data_n2", 64'(bus.rd_data), 64'h0000_0000_A5A5_0001);
    drain();

    // Fill to capacity 2^DW + 2 with no reads
    for (int w = 0; w < 18; w++) push_word(XW'(w));
    check_eq("full_wr_ready", 64'(bus.wr_ready), 64'(0));
    check_eq("full_count", 64'(bus.count), 64'(18));
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'h0000_0099;
    for (int i = 0; i < 3; i++) tick();
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b1;
    tick();
    check_eq("full_wr_ready_reassert", 64'(bus.wr_ready), 64'(1));
    drain();

    // Continuous push and pop: no bubbles, constant occupancy
    bus.rd_ready = 1'b1;
    bus.wr_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bus.wr_data = 32'h5000_0000 + XW'(i);
      tick();
      check_eq("stream_accept", 64'(last_acc), 64'(1));
      if (i >= 3) begin
        check_eq("stream_rd_valid", 64'(bus.rd_valid), 64'(1));
        check_eq("stream_count", 64'(bus.count), 64'(3));
      end
    end
    drain();

    // Random stalls on both sides across several pointer wraps
    sent = 0;
    for (int g = 0; g < 2000 && sent < 48; g++) begin
      bus.wr_valid = ($urandom_range(0, 3) != 0);
      bus.wr_data  = 32'hB000_0000 + XW'(sent);
      bus.rd_ready = ($urandom_range(0, 1) != 0);
      tick();
      if (last_acc) sent++;
    end
    check_eq("random_sent", 64'(sent), 64'(48));
    drain();

    // Flush with count=7, a fetch in flight and a simultaneous push
    for (int w = 0; w < 8; w++) push_word(32'hC000_0000 + XW'(w));
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    check_eq("preflush_count", 64'(bus.count), 64'(7));
    bus.flush    = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'h0000_DEAD;
    tick();
    bus.flush    = 1'b0;
    bus.wr_valid = 1'b0;
    check_eq("flush_count", 64'(bus.count), 64'(0));
    check_eq("flush_rd_valid", 64'(bus.rd_valid), 64'(0));
    check_eq("flush_wr_ready", 64'(bus.wr_ready), 64'(1));
    for (int i = 0; i < 3; i++) tick();
    check_eq("flush_stays_empty", 64'(bus.rd_valid), 64'(0));
    push_word(32'h0000_1234);
    drain();

    // Reset pulse mid-stream with count=5
    for (int w = 0; w < 5; w++) push_word(32'hD000_0000 + XW'(w));
    check_eq("prereset_count", 64'(bus.count), 64'(5));
    rst_n        = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'h0000_BEEF;
    tick();
    rst_n        = 1'b1;
    bus.wr_valid = 1'b0;
    #1;
    check_reset_outputs("midreset");
    for (int w = 0; w < 3; w++) push_word(32'hE000_0000 + XW'(w));
    drain();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
